pipeline_control_unit: RTL and testbench

- Consumer side of the main decoder's control bundle.
- Latches the ID-stage control word and register fields into the ID/EX, EX/MEM and MEM/WB control pipeline.
- Detects load-use hazards (stall plus bubble), flushes on taken branch/jump, and generates EX-stage forwarding selects.
- Keeps saturating stall/flush performance counters. Sits between the decoder and the datapath pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_control_unit.sv | 135 +++++++++++++
 tb/tb_pipeline_control_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the ID/EX/MEM/WB control pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: control-word bit indices, the all-zero bubble word, forwarding select codes.
package pipe_ctrl_pkg;

  // Control word bit positions as produced by the main decoder
  localparam int CTRL_REGDST   = 9;
  localparam int CTRL_JUMP     = 8;
  localparam int CTRL_BRANCH   = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUOP_HI = 4;
  localparam int CTRL_ALUOP_LO = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGWRITE = 0;

  // A bubble is an all-zero control word: no memory access, no register write
  localparam logic [9:0] BUBBLE = 10'b0;

  // ALU operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance events.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, clear_n (sync active-low clear), en (count this cycle), count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Control pipeline ID->EX->MEM->WB with load-use stall, branch/jump flush and EX forwarding selects.
// Latency: EX_Ctrl 1 cycle after ID, MEM_* 2 cycles, WB_* 3 cycles; hazard/flush/forward outputs are combinational.
// Backpressure: PCWrite/IFIDWrite drop for exactly one cycle per load-use pair; ID/EX takes a bubble instead.
// Ports: Clk, Reset (sync active-low); ID_* decoder fields in; EX_BranchTaken in;
//        PCWrite/IFIDWrite/IFIDFlush to fetch; EX_*/MEM_*/WB_* staged control; ForwardA/B; StallCount/FlushCount.
module pipeline_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W = 10,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_UsesRt,
  input  logic              EX_BranchTaken,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [REG_W-1:0]  EX_Rs,
  output logic [REG_W-1:0]  EX_Rt,
  output logic [REG_W-1:0]  EX_Dest,
  output logic              MEM_MemRead,
  output logic              MEM_MemWrite,
  output logic              MEM_MemToReg,
  output logic              MEM_RegWrite,
  output logic [REG_W-1:0]  MEM_Dest,
  output logic              WB_MemToReg,
  output logic              WB_RegWrite,
  output logic [REG_W-1:0]  WB_Dest,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  logic [REG_W-1:0]  id_dest;
  logic [CTRL_W-1:0] id_ctrl_cap;
  logic              hazard_raw;
  logic              br_flush;
  logic              hazard;
  logic              insert_bubble;

  // Youngest in-flight producer wins; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic             mem_rw,
    input logic [REG_W-1:0] mem_dest,
    input logic             wb_rw,
    input logic [REG_W-1:0] wb_dest,
    input logic [REG_W-1:0] src
  );
    if (mem_rw && (mem_dest != '0) && (mem_dest == src)) return FWD_MEM;
    if (wb_rw && (wb_dest != '0) && (wb_dest == src))    return FWD_WB;
    return FWD_REG;
  endfunction

  always_comb begin
    id_dest     = ID_Ctrl[CTRL_REGDST] ? ID_Rd : ID_Rt;
    id_ctrl_cap = ID_Ctrl;
    // Writes to $0 are dropped here so later stages never see them as producers
    if (id_dest == '0) id_ctrl_cap[CTRL_REGWRITE] = 1'b0;

    hazard_raw = EX_Ctrl[CTRL_MEMREAD] && (EX_Dest != '0) &&
                 ((EX_Dest == ID_Rs) || (ID_UsesRt && (EX_Dest == ID_Rt)));
    br_flush   = EX_Ctrl[CTRL_BRANCH] && EX_BranchTaken;
    // A taken branch squashes the stalled instruction anyway, so the stall is dropped
    hazard     = hazard_raw && !br_flush;

    PCWrite       = !hazard;
    IFIDWrite     = !hazard;
    // A jump held in ID by a stall must not flush itself out of IF/ID
    IFIDFlush     = br_flush || (ID_Ctrl[CTRL_JUMP] && !hazard);
    insert_bubble = br_flush || hazard;

    ForwardA = fwd_sel(MEM_RegWrite, MEM_Dest, WB_RegWrite, WB_Dest, EX_Rs);
    ForwardB = fwd_sel(MEM_RegWrite, MEM_Dest, WB_RegWrite, WB_Dest, EX_Rt);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      EX_Ctrl      <= BUBBLE;
      EX_Rs        <= '0;
      EX_Rt        <= '0;
      EX_Dest      <= '0;
      MEM_MemRead  <= 1'b0;
      MEM_MemWrite <= 1'b0;
      MEM_MemToReg <= 1'b0;
      MEM_RegWrite <= 1'b0;
      MEM_Dest     <= '0;
      WB_MemToReg  <= 1'b0;
      WB_RegWrite  <= 1'b0;
      WB_Dest      <= '0;
    end else begin
      if (insert_bubble) begin
        EX_Ctrl <= BUBBLE;
        EX_Rs   <= '0;
        EX_Rt   <= '0;
        EX_Dest <= '0;
      end else begin
        EX_Ctrl <= id_ctrl_cap;
        EX_Rs   <= ID_Rs;
        EX_Rt   <= ID_Rt;
        EX_Dest <= id_dest;
      end
      MEM_MemRead  <= EX_Ctrl[CTRL_MEMREAD];
      MEM_MemWrite <= EX_Ctrl[CTRL_MEMWRITE];
      MEM_MemToReg <= EX_Ctrl[CTRL_MEMTOREG];
      MEM_RegWrite <= EX_Ctrl[CTRL_REGWRITE];
      MEM_Dest     <= EX_Dest;
      WB_MemToReg  <= MEM_MemToReg;
      WB_RegWrite  <= MEM_RegWrite;
      WB_Dest      <= MEM_Dest;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (Clk),
    .clear_n (Reset),
    .en      (hazard),
    .count   (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (Clk),
    .clear_n (Reset),
    .en      (IFIDFlush),
    .count   (FlushCount)
  );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: instruction-level reference model predicts every cycle's outputs.
// Counters are instantiated narrow so saturation is reachable in a short run.
module tb_pipeline_control_unit;

  localparam int CTRL_W = 10;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;

  // Decoder control word layout
  localparam int B_REGDST = 9, B_JUMP = 8, B_BRANCH = 7, B_MEMREAD = 6, B_MEMTOREG = 5;
  localparam int B_MEMWRITE = 2, B_REGWRITE = 0;

  localparam logic [9:0] I_NOP  = 10'b0000000000;
  localparam logic [9:0] I_LW   = 10'b0001100011; // MemRead MemToReg ALUSrc RegWrite
  localparam logic [9:0] I_ADD  = 10'b1000010001; // RegDst ALUOp=10 RegWrite
  localparam logic [9:0] I_BRLD = 10'b0011000000; // Branch + MemRead (contrived coincidence)
  localparam logic [9:0] I_J    = 10'b0100000000;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [CTRL_W-1:0] ID_Ctrl;
  logic [REG_W-1:0]  ID_Rs, ID_Rt, ID_Rd;
  logic              ID_UsesRt, EX_BranchTaken;
  logic              PCWrite, IFIDWrite, IFIDFlush;
  logic [CTRL_W-1:0] EX_Ctrl;
  logic [REG_W-1:0]  EX_Rs, EX_Rt, EX_Dest;
  logic              MEM_MemRead, MEM_MemWrite, MEM_MemToReg, MEM_RegWrite;
  logic [REG_W-1:0]  MEM_Dest;
  logic              WB_MemToReg, WB_RegWrite;
  logic [REG_W-1:0]  WB_Dest;
  logic [1:0]        ForwardA, ForwardB;
  logic [CNT_W-1:0]  StallCount, FlushCount;

  always #5 Clk = ~Clk;

  pipeline_control_unit #(.CTRL_W(CTRL_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .ID_Ctrl(ID_Ctrl), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_UsesRt(ID_UsesRt), .EX_BranchTaken(EX_BranchTaken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .EX_Ctrl(EX_Ctrl), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Dest(EX_Dest),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_MemToReg(MEM_MemToReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_Dest(MEM_Dest),
    .WB_MemToReg(WB_MemToReg), .WB_RegWrite(WB_RegWrite), .WB_Dest(WB_Dest),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // One in-flight instruction as the model sees it
  typedef struct packed {
    logic [9:0] ctrl;
    logic [4:0] rs, rt, dest;
  } rec_t;

  typedef struct packed {
    logic             chk;
    logic             pcw, ifidw, ifidf;
    logic [9:0]       exctrl;
    logic [4:0]       exrs, exrt, exdest;
    logic             mmr, mmw, mmtr, mrw;
    logic [4:0]       mdest;
    logic             wmtr, wrw;
    logic [4:0]       wdest;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t exq[$];
  rec_t m_ex, m_mem, m_wb;
  int   m_sc, m_fc;
  bit   known = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (src != 0 && m_mem.ctrl[B_REGWRITE] && m_mem.dest == src) return 2'b10;
    if (src != 0 && m_wb.ctrl[B_REGWRITE] && m_wb.dest == src)   return 2'b01;
    return 2'b00;
  endfunction

  // Drive one cycle of ID inputs, predict this cycle's outputs, then advance the model
  task automatic step(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic ur, input logic tk, input logic rst);
    exp_t e;
    rec_t n;
    logic hz, br, stl, fl;
    Reset = rst; ID_Ctrl = c; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
    ID_UsesRt = ur; EX_BranchTaken = tk;

    hz  = m_ex.ctrl[B_MEMREAD] && m_ex.dest != 0 && (m_ex.dest == rs || (ur && m_ex.dest == rt));
    br  = m_ex.ctrl[B_BRANCH] && tk;
    stl = hz && !br;
    fl  = br || (c[B_JUMP] && !stl);

    e.chk    = known;
    e.pcw    = !stl;
    e.ifidw  = !stl;
    e.ifidf  = fl;
    e.exctrl = m_ex.ctrl;
    e.exrs   = m_ex.rs;
    e.exrt   = m_ex.rt;
    e.exdest = m_ex.dest;
    e.mmr    = m_mem.ctrl[B_MEMREAD];
    e.mmw    = m_mem.ctrl[B_MEMWRITE];
    e.mmtr   = m_mem.ctrl[B_MEMTOREG];
    e.mrw    = m_mem.ctrl[B_REGWRITE];
    e.mdest  = m_mem.dest;
    e.wmtr   = m_wb.ctrl[B_MEMTOREG];
    e.wrw    = m_wb.ctrl[B_REGWRITE];
    e.wdest  = m_wb.dest;
    e.fa     = model_fwd(m_ex.rs);
    e.fb     = model_fwd(m_ex.rt);
    e.sc     = CNT_W'(m_sc);
    e.fc     = CNT_W'(m_fc);
    exq.push_back(e);

    if (!rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_sc = 0; m_fc = 0; known = 1'b1;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      if (br || stl) begin
        m_ex = '0;
      end else begin
        n.ctrl = c; n.rs = rs; n.rt = rt;
        n.dest = c[B_REGDST] ? rd : rt;
        if (n.dest == 0) n.ctrl[B_REGWRITE] = 1'b0;
        m_ex = n;
      end
      if (stl && m_sc < MAXC) m_sc++;
      if (fl && m_fc < MAXC) m_fc++;
    end
    @(posedge Clk);
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare away from the clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        if (e.chk) begin
          chk("PCWrite",      32'(PCWrite),      32'(e.pcw));
          chk("IFIDWrite",    32'(IFIDWrite),    32'(e.ifidw));
          chk("IFIDFlush",    32'(IFIDFlush),    32'(e.ifidf));
          chk("EX_Ctrl",      32'(EX_Ctrl),      32'(e.exctrl));
          chk("EX_Rs",        32'(EX_Rs),        32'(e.exrs));
          chk("EX_Rt",        32'(EX_Rt),        32'(e.exrt));
          chk("EX_Dest",      32'(EX_Dest),      32'(e.exdest));
          chk("MEM_MemRead",  32'(MEM_MemRead),  32'(e.mmr));
          chk("MEM_MemWrite", 32'(MEM_MemWrite), 32'(e.mmw));
          chk("MEM_MemToReg", 32'(MEM_MemToReg), 32'(e.mmtr));
          chk("MEM_RegWrite", 32'(MEM_RegWrite), 32'(e.mrw));
          chk("MEM_Dest",     32'(MEM_Dest),     32'(e.mdest));
          chk("WB_MemToReg",  32'(WB_MemToReg),  32'(e.wmtr));
          chk("WB_RegWrite",  32'(WB_RegWrite),  32'(e.wrw));
          chk("WB_Dest",      32'(WB_Dest),      32'(e.wdest));
          chk("ForwardA",     32'(ForwardA),     32'(e.fa));
          chk("ForwardB",     32'(ForwardB),     32'(e.fb));
          chk("StallCount",   32'(StallCount),   32'(e.sc));
          chk("FlushCount",   32'(FlushCount),   32'(e.fc));
        end
      end
    end
  end

  initial begin
    Reset = 1'b0; ID_Ctrl = '0; ID_Rs = '0; ID_Rt = '0; ID_Rd = '0;
    ID_UsesRt = 1'b0; EX_BranchTaken = 1'b0;
    m_ex = '0; m_mem = '0; m_wb = '0; m_sc = 0; m_fc = 0;
    @(posedge Clk);
    #1;

    // Reset held with random ID inputs
    repeat (2) step(10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    1'($urandom), 1'($urandom), 1'b0);
    step(I_NOP, 0, 0, 0, 0, 0, 1);

    // lw $8 ; add $9,$8,$10 -> one stall, then MEM/WB forward
    step(I_LW,  5'd1, 5'd8,  5'd0, 0, 0, 1);
    step(I_ADD, 5'd8, 5'd10, 5'd9, 1, 0, 1);
    step(I_ADD, 5'd8, 5'd10, 5'd9, 1, 0, 1);
    step(I_NOP, 0, 0, 0, 0, 0, 1);

    // add $5 ; sub $6,$5,$5 -> EX/MEM forward on both operands
    step(I_ADD, 5'd1, 5'd2, 5'd5, 1, 0, 1);
    step(I_ADD, 5'd5, 5'd5, 5'd6, 1, 0, 1);
    step(I_NOP, 0, 0, 0, 0, 0, 1);

    // lw to $0 followed by use of $0 -> no stall, no forward
    step(I_LW,  5'd1, 5'd0, 5'd0, 0, 0, 1);
    step(I_ADD, 5'd0, 5'd0, 5'd3, 1, 0, 1);
    step(I_NOP, 0, 0, 0, 0, 0, 1);
    step(I_NOP, 0, 0, 0, 0, 0, 1);

    // Taken branch in EX coinciding with a load-use hazard in ID
    step(I_BRLD, 5'd1, 5'd7, 5'd0, 0, 0, 1);
    step(I_ADD,  5'd7, 5'd2, 5'd4, 1, 1, 1);
    step(I_NOP, 0, 0, 0, 0, 0, 1);

    // Jump in ID
    step(I_J, 0, 0, 0, 0, 0, 1);
    step(I_NOP, 0, 0, 0, 0, 0, 1);
    step(I_NOP, 0, 0, 0, 0, 0, 1);

    // Random traffic on a small register set, with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(10'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 49) != 0));
    end

    // Drive both counters past saturation
    step(I_NOP, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MAXC + 40; i++) begin
      step(I_LW,  5'd2, 5'd1, 5'd0, 0, 0, 1);
      step(I_ADD, 5'd1, 5'd3, 5'd4, 1, 0, 1);
    end
    for (int i = 0; i < MAXC + 40; i++) step(I_J, 0, 0, 0, 0, 0, 1);

    // Reset mid-operation discards in-flight control
    step(I_LW, 5'd1, 5'd2, 5'd0, 0, 0, 1);
    step(I_ADD, 5'd2, 5'd1, 5'd3, 1, 0, 0);
    step(I_NOP, 0, 0, 0, 0, 0, 1);
    step(I_NOP, 0, 0, 0, 0, 0, 1);

    // Let the monitor drain, bounded
    for (int i = 0; i < 5 && exq.size() > 0; i++) @(negedge Clk);
    #1;
    checks++;
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
